fft_bitrev_buffer: RTL and testbench
====================================

// Module: fft_bitrev_buffer
// PURPOSE
//  Input reorder stage directly upstream of the butterfly datapath. Accepts a stream of
//  packed complex samples ({re[31:16], im[15:0]}, two's complement) in natural order.
//  Re-emits each N-point frame in bit-reversed order, as needed by the decimation-in-time
//  butterfly stages. Ping-pong banks allow one frame to fill while the previous one drains,
//  giving 1 sample/cycle sustained throughput.
// PARAMETERS
//  LOG2N   4   log2 of frame length; N = 2**LOG2N points per frame (LOG2N >= 1)
//  DATA_W  32  sample width; passed through unmodified (no arithmetic on data)
// PORTS
//  Clk        in   1       clock, all state on rising edge
//  Rst        in   1       asynchronous reset, active-low (Rst==0 resets)
//  in_data    in   DATA_W  input sample, natural order
//  in_valid   in   1       in_data valid
//  in_ready   out  1       buffer can accept; handshake = in_valid & in_ready
//  out_data   out  DATA_W  output sample, bit-reversed order within frame
//  out_valid  out  1       out_data valid
//  out_ready  in   1       downstream accepts; handshake = out_valid & out_ready
//  out_last   out  1       qualifies the final (N-th) sample of a frame
// BEHAVIOUR
//  - Storage: 2 banks x N words. Per bank a 'full' flag. Pointers wr_bank, rd_bank, wr_cnt, rd_cnt (LOG2N bits).
//  - Reset (async, Rst=0): wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, both full=0.
//    out_valid=0, out_last=0, out_data=0. in_ready reads 1 once Rst=1.
//    Memory contents are not reset.
//  - Reset mid-operation: partial and stored frames discarded; out_valid drops asynchronously.
//    The first input after release is sample 0 of a new frame.
//  - Write side: in_ready = !full[wr_bank] (combinational from registers, not from out_ready).
//    On input handshake: bank[wr_bank][wr_cnt] <= in_data; wr_cnt++.
//    If wr_cnt==N-1: full[wr_bank]<=1, wr_bank toggles, wr_cnt wraps to 0.
//  - Read side: output register stage. It loads when full[rd_bank] && (!out_valid || out_ready).
//    Load: out_data <= bank[rd_bank][bitrev(rd_cnt)], out_valid<=1, out_last<=(rd_cnt==N-1), rd_cnt++.
//    If rd_cnt==N-1: full[rd_bank]<=0, rd_bank toggles, rd_cnt wraps to 0.
//    If no load and out_ready: out_valid<=0, out_last<=0.
//  - bitrev(k): bit i of address = bit LOG2N-1-i of k.
//  - Latency: the last input handshake of a frame occurs at edge k. out_valid (first sample of
//    that frame, if the output stage is free) rises after edge k+1.
//  - Throughput: in_valid=1 and out_ready=1 continuously gives no bubbles on either side after the first frame.
//  - Simultaneous events: in one edge, the write side may set full[x] while the read side clears full[y], x!=y.
//    Both take effect. full of the same bank is never set and cleared at once, because the write
//    and read banks differ whenever both are active.
//  - Full: both banks full and out stalled => in_ready=0. in_valid is ignored; no data loss or overwrite.
//  - Empty: no full bank => output register holds until drained, then out_valid=0.
//  - out_data/out_last hold stable while out_valid && !out_ready.
// TESTING
//  1 Rst=0 with random inputs -> out_valid=0, out_last=0, out_data=0. After release, in_ready=1.
//  2 LOG2N=4, one frame in_data=i (i=0..15), out_ready=1 -> out sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
//    out_last only with 15. First out_valid 1 edge after the 16th accept.
//  3 Three back-to-back frames, in_valid=out_ready=1 -> in_ready never 0.
//    Output continuous 48 samples, out_last at samples 16/32/48.
//  4 out_ready=0, 40 samples offered -> exactly 32 accepted, then in_ready=0.
//    Raising out_ready drains frame 1 in bit-reversed order, then in_ready=1.
//  5 Random in_valid/out_ready (50%), 200 frames -> output matches reference bitrev model.
//    No drop, no duplicate, data stable while stalled.
//  6 Rst pulse low after 7 samples of a frame -> out_valid=0 at once.
//    A new 16-sample frame afterwards is emitted alone, correctly reordered.

Source files
------------

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong reorder buffer: fills one N-point bank in natural order while the other
// drains through a registered output stage in bit-reversed order.
module fft_bitrev_buffer #(
  parameter int unsigned LOG2N  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CntMax = '1;

  logic [DATA_W-1:0] mem_q [2*N];

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic              wr_en;
  logic              rd_en;
  logic [LOG2N-1:0]  rd_addr;

  assign in_ready  = ~full_q[wr_bank_q];
  assign wr_en     = in_valid & in_ready;
  // Output register reloads whenever it is empty or being consumed this cycle.
  assign rd_en     = full_q[rd_bank_q] & (~out_valid_q | out_ready);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      rd_addr[i] = rd_cnt_q[int'(LOG2N) - 1 - i];
    end
  end

  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == CntMax) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // Write and read banks differ whenever both are active, so these never collide.
    if (rd_en) begin
      out_data_d  = mem_q[{rd_bank_q, rd_addr}];
      out_valid_d = 1'b1;
      out_last_d  = (rd_cnt_q == CntMax);
      rd_cnt_d    = rd_cnt_q + 1'b1;
      if (rd_cnt_q == CntMax) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[{wr_bank_q, wr_cnt_q}] <= in_data;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Bench for fft_bitrev_buffer: a negedge monitor models frames and scoreboards every output
// handshake; scenario tasks add their own timing, flow-control and reset checks.
module tb_fft_bitrev_buffer;

  localparam int LOG2N = 4;
  localparam int N     = 16;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;

  fft_bitrev_buffer #(.LOG2N(LOG2N), .DATA_W(32)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] frame_buf [N];
  int          in_cnt = 0;
  int          out_hs = 0;
  int          checks = 0;
  int          passes = 0;
  int          drv_timeouts = 0;
  int          ready_stalls = 0;
  bit          held = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;

  function automatic int bitrev(input int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  // Scoreboard monitor: inputs accepted at the coming edge build frames; outputs are popped.
  always @(negedge Clk) begin
    if (!Rst) begin
      exp_q.delete();
      in_cnt = 0;
      held   = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        frame_buf[in_cnt] = in_data;
        in_cnt++;
        if (in_cnt == N) begin
          for (int k = 0; k < N; k++) exp_q.push_back({frame_buf[bitrev(k)], k == N - 1});
          in_cnt = 0;
        end
      end
      if (held) begin
        checks++;
        if (!out_valid || out_data !== held_data || out_last !== held_last)
          $display("FAIL stall_hold: got v=%0b d=%h l=%0b, required v=1 d=%h l=%0b",
                   out_valid, out_data, out_last, held_data, held_last);
        else passes++;
      end
      if (out_valid && out_ready) begin
        checks++;
        out_hs++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_output: got d=%h l=%0b, required no output", out_data, out_last);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e.data || out_last !== mon_e.last)
            $display("FAIL out_sample: got d=%h l=%0b, required d=%h l=%0b",
                     out_data, out_last, mon_e.data, mon_e.last);
          else passes++;
        end
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
    end
  end

  // Holds in_valid until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge Clk);
    while (!in_ready && n < 2000) begin
      ready_stalls++;
      n++;
      @(negedge Clk);
    end
    if (!in_ready) drv_timeouts++;
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge Clk);
      #1;
      n++;
    end
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #1 Rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge Clk);
      #1;
      in_valid  = 1'($urandom_range(1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(1));
      @(negedge Clk);
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0)
        $display("FAIL reset_outputs: got v=%0b l=%0b d=%h, required 0 0 0",
                 out_valid, out_last, out_data);
      else passes++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    else passes++;
  endtask

  task automatic test_single_frame();
    int base;
    out_ready = 1'b1;
    base = out_hs;
    for (int i = 0; i < N; i++) send(32'(i));
    in_valid = 1'b0;
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL latency_early: got out_valid=%0b, required 0", out_valid);
    else passes++;
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd0)
      $display("FAIL latency_first: got v=%0b d=%0d, required v=1 d=0", out_valid, out_data);
    else passes++;
    @(negedge Clk);
    checks++;
    if (out_data !== 32'd8) $display("FAIL second_sample: got %0d, required 8", out_data);
    else passes++;
    wait_empty(100);
    checks++;
    if (out_hs - base != N || exp_q.size() != 0)
      $display("FAIL single_frame_count: got %0d outputs (%0d pending), required 16 (0)",
               out_hs - base, exp_q.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    int s0;
    int gaps = 0;
    int bad_last = 0;
    int base;
    out_ready = 1'b1;
    s0   = ready_stalls;
    base = out_hs;
    fork
      begin
        for (int i = 0; i < 3 * N; i++) send(32'(1000 + i));
        in_valid = 1'b0;
      end
      begin
        int n = 0;
        @(negedge Clk);
        while (!out_valid && n < 100) begin
          n++;
          @(negedge Clk);
        end
        for (int j = 1; j <= 3 * N; j++) begin
          if (!out_valid) gaps++;
          if (out_last !== (j % N == 0)) bad_last++;
          @(negedge Clk);
        end
      end
    join
    wait_empty(100);
    checks++;
    if (ready_stalls != s0) $display("FAIL b2b_in_ready: got %0d stalls, required 0", ready_stalls - s0);
    else passes++;
    checks++;
    if (gaps != 0) $display("FAIL b2b_out_gaps: got %0d bubbles, required 0", gaps);
    else passes++;
    checks++;
    if (bad_last != 0) $display("FAIL b2b_out_last: got %0d misplaced, required 0", bad_last);
    else passes++;
    checks++;
    if (out_hs - base != 3 * N) $display("FAIL b2b_count: got %0d, required 48", out_hs - base);
    else passes++;
  endtask

  task automatic test_full();
    int acc = 0;
    int n = 0;
    int base;
    base      = out_hs;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd2000;
    for (int c = 0; c < 60; c++) begin
      @(negedge Clk);
      if (in_valid && in_ready) acc++;
      @(posedge Clk);
      #1;
      in_data = 32'(2000 + acc);
      if (acc >= 40) in_valid = 1'b0;
    end
    checks++;
    if (acc != 2 * N) $display("FAIL full_accepted: got %0d, required 32", acc);
    else passes++;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %0b, required 0", in_ready);
    else passes++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) $display("FAIL full_release: got in_ready=%0b, required 1", in_ready);
    else passes++;
    wait_empty(200);
    checks++;
    if (out_hs - base != 2 * N || exp_q.size() != 0)
      $display("FAIL full_drain: got %0d outputs (%0d pending), required 32 (0)",
               out_hs - base, exp_q.size());
    else passes++;
  endtask

  task automatic test_random();
    int base;
    bit done = 1'b0;
    base = out_hs;
    fork
      begin
        for (int i = 0; i < 200 * N; i++) begin
          while ($urandom_range(1) == 1) begin
            in_valid = 1'b0;
            @(posedge Clk);
            #1;
          end
          send($urandom);
        end
        in_valid = 1'b0;
        done     = 1'b1;
      end
      begin
        int n = 0;
        while (!(done && exp_q.size() == 0) && n < 60000) begin
          @(posedge Clk);
          #1;
          out_ready = 1'($urandom_range(1));
          n++;
        end
      end
    join
    out_ready = 1'b1;
    wait_empty(100);
    checks++;
    if (out_hs - base != 200 * N || exp_q.size() != 0)
      $display("FAIL random_count: got %0d outputs (%0d pending), required 3200 (0)",
               out_hs - base, exp_q.size());
    else passes++;
  endtask

  task automatic test_mid_reset();
    int base;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(32'(3000 + i));
    in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    for (int i = 0; i < 7; i++) send(32'(4000 + i));
    in_valid = 1'b0;
    @(posedge Clk);
    #2;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL mid_reset_pre: got out_valid=%0b, required 1", out_valid);
    else passes++;
    Rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0)
      $display("FAIL mid_reset_async: got v=%0b l=%0b d=%h, required 0 0 0",
               out_valid, out_last, out_data);
    else passes++;
    @(posedge Clk);
    #2 Rst = 1'b1;
    base      = out_hs;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(32'(5000 + i));
    in_valid = 1'b0;
    wait_empty(100);
    repeat (20) @(posedge Clk);
    #1;
    checks++;
    if (out_hs - base != N || exp_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL mid_reset_frame: got %0d outputs v=%0b, required 16 v=0",
               out_hs - base, out_valid);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full();
    test_random();
    test_mid_reset();
    checks++;
    if (drv_timeouts != 0) $display("FAIL driver_timeout: got %0d, required 0", drv_timeouts);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
